fifo: RTL and testbench

// Synchronous single-clock FIFO queue with a registered read-data output.

---
 rtl/fifo.sv | 62 ++++++
 tb/tb_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock FIFO with a registered read-data output.
// Capacity may be any positive integer; pointers wrap by explicit compare.
module fifo #(
  parameter int Size      = 10,
  parameter int EntrySize = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_req_i,
  output logic                 write_valid_o,
  input  logic                 read_req_i,
  output logic                 read_valid_o,
  input  logic [EntrySize-1:0] data_i,
  output logic [EntrySize-1:0] data_o
);

  localparam int PW = (Size > 1) ? $clog2(Size) : 1;
  localparam int CW = $clog2(Size + 1);
  localparam logic [PW-1:0] LAST = PW'(Size - 1);
  localparam logic [CW-1:0] FULL = CW'(Size);

  logic [EntrySize-1:0] r_mem [Size];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_push;
  logic                 w_pop;

  assign write_valid_o = (r_count != FULL);
  assign read_valid_o  = (r_count != '0);
  // Requests that arrive while the matching valid is low are simply dropped.
  assign w_push = write_req_i && write_valid_o;
  assign w_pop  = read_req_i && read_valid_o;

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // Pointers, occupancy and registered output. The pop reads the old head,
  // so a same-cycle push to a different slot can never be observed here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      data_o   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        data_o   <= r_mem[r_rd_ptr];
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed + randomized bench for fifo against a queue-based reference model.
module tb_fifo;
  localparam int SIZE = 10;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req, rd_req;
  logic         wr_vld, rd_vld;
  logic [W-1:0] din, dout;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout;

  fifo #(.Size(SIZE), .EntrySize(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .write_req_i(wr_req), .write_valid_o(wr_vld),
    .read_req_i(rd_req), .read_valid_o(rd_vld),
    .data_i(din), .data_o(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rvld"}, 32'(rd_vld), 32'(q.size() != 0));
    chk({tag, ".wvld"}, 32'(wr_vld), 32'(q.size() != SIZE));
    chk({tag, ".dout"}, 32'(dout), 32'(exp_dout));
  endtask

  // One clock cycle of stimulus; model is updated from the pre-edge state.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    bit can_push, can_pop;
    wr_req = w; rd_req = r; din = d;
    @(posedge clk);
    can_push = w && (q.size() != SIZE);
    can_pop  = r && (q.size() != 0);
    if (can_pop)  exp_dout = q.pop_front();
    if (can_push) q.push_back(d);
    #1;
    chk_all(tag);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; din = '0; exp_dout = '0;
    #1;
    chk_all("in_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("after_reset");
    @(negedge clk);

    // Single round trip
    cyc(1, 0, 8'hAB, "push_ab");
    cyc(0, 1, 8'h00, "pop_ab");
    chk("pop_ab.val", 32'(dout), 32'h000000AB);

    // Fill to full, then drain
    for (int i = 0; i < SIZE; i++) cyc(1, 0, W'(i), "fill");
    chk("full.wvld", 32'(wr_vld), 32'd0);
    cyc(1, 0, 8'hEE, "push_full");
    for (int i = 0; i < SIZE; i++) cyc(0, 1, 8'h00, "drain");
    chk("drain.last", 32'(dout), 32'(SIZE - 1));
    cyc(0, 1, 8'h00, "pop_empty");

    // Streaming push+pop at occupancy 1
    cyc(1, 0, 8'h00, "stream0");
    for (int i = 1; i < SIZE; i++) cyc(1, 1, W'(i), "stream");
    cyc(0, 1, 8'h00, "stream_end");

    // Simultaneous push+pop while empty and while full
    cyc(1, 1, 8'h5A, "both_empty");
    for (int i = 0; i < SIZE - 1; i++) cyc(1, 0, W'(8'h60 + i), "refill");
    cyc(1, 1, 8'h77, "both_full");
    cyc(1, 1, 8'h78, "both_nearfull");

    // Async reset mid-stream with entries queued
    while (q.size() > 5) cyc(0, 1, 8'h00, "trim");
    #2 rst = 1'b1;
    #1;
    q.delete(); exp_dout = '0;
    chk_all("async_rst");
    @(negedge clk); rst = 1'b0;
    cyc(1, 0, 8'hC3, "post_rst_push");
    cyc(0, 1, 8'h00, "post_rst_pop");

    // Randomized traffic, with phases biased toward full and toward empty
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      cyc((bias == 0) ? ($urandom_range(9, 0) < 8) :
          (bias == 1) ? ($urandom_range(9, 0) < 2) : 1'($urandom),
          (bias == 0) ? ($urandom_range(9, 0) < 2) :
          (bias == 1) ? ($urandom_range(9, 0) < 8) : 1'($urandom),
          W'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
